// File: rtl/ahb_decoder_mux.sv
// Single-master AHB-Lite address decoder with slave response mux and an
// ERROR-returning default slave for unmapped space.
module ahb_decoder_mux #(
  parameter logic [31:0] S0_BASE     = 32'h0000_0000,
  parameter logic [31:0] S1_BASE     = 32'h2000_0000,
  parameter logic [31:0] S2_BASE     = 32'h4000_0000,
  parameter int          REGION_BITS = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HSEL0,
  output logic        HSEL1,
  output logic        HSEL2,
  output logic        HREADY,
  input  logic        HREADYOUT0,
  input  logic        HREADYOUT1,
  input  logic        HREADYOUT2,
  input  logic [31:0] HRDATA0,
  input  logic [31:0] HRDATA1,
  input  logic [31:0] HRDATA2,
  input  logic        HRESP0,
  input  logic        HRESP1,
  input  logic        HRESP2,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;
  localparam logic [1:0] SEL_DEF = 2'd3;

  logic       match0, match1, match2;
  logic [1:0] dec_sel;
  logic [1:0] dsel_q, dsel_d;
  logic [1:0] state_q, state_d;
  logic       unmapped_req;
  logic       def_ready, def_resp;
  logic       unused_ok;

  assign match0 = (HADDR[31:REGION_BITS] == S0_BASE[31:REGION_BITS]);
  assign match1 = (HADDR[31:REGION_BITS] == S1_BASE[31:REGION_BITS]);
  assign match2 = (HADDR[31:REGION_BITS] == S2_BASE[31:REGION_BITS]);

  // Priority keeps the selects one-hot even if two bases are configured to overlap.
  assign HSEL0 = match0;
  assign HSEL1 = match1 & ~match0;
  assign HSEL2 = match2 & ~match0 & ~match1;

  always_comb begin
    dec_sel = SEL_DEF;
    if (HSEL0)      dec_sel = 2'd0;
    else if (HSEL1) dec_sel = 2'd1;
    else if (HSEL2) dec_sel = 2'd2;
  end

  assign def_ready = (state_q != ST_ERR1);
  assign def_resp  = (state_q != ST_IDLE);

  always_comb begin
    HREADY = def_ready;
    HRESP  = def_resp;
    HRDATA = 32'h0;
    case (dsel_q)
      2'd0: begin HREADY = HREADYOUT0; HRESP = HRESP0; HRDATA = HRDATA0; end
      2'd1: begin HREADY = HREADYOUT1; HRESP = HRESP1; HRDATA = HRDATA1; end
      2'd2: begin HREADY = HREADYOUT2; HRESP = HRESP2; HRDATA = HRDATA2; end
      default: ;
    endcase
  end

  // Only NONSEQ/SEQ into unmapped space earns an ERROR; IDLE/BUSY get zero-wait OKAY.
  assign unmapped_req = HREADY & HTRANS[1] & (dec_sel == SEL_DEF);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (unmapped_req) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = unmapped_req ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dsel_d = HREADY ? dec_sel : dsel_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q  <= SEL_DEF;
      state_q <= ST_IDLE;
    end else begin
      dsel_q  <= dsel_d;
      state_q <= state_d;
    end
  end

  assign unused_ok = ^{HTRANS[0], HADDR[REGION_BITS-1:0]};

endmodule
